// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART word receive path.
package uart_pkg;

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } asmState_e;

  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_WORD_W         = 32;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int timerWidth(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Silence timer: counts cycles while run is high, restarts on each byte,
// and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_idle_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CntW = timerWidth(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count;

  assign expired = run && (count == LastCount);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || restart || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_rx_ctrl.sv
// Assembles received UART bytes into 32-bit little-endian words behind a
// one-word holding register. Define UART_RX_TIMEOUT_EN to enable the silence timeout.
module uart_word_rx_ctrl
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_error,
  output logic [UART_WORD_W-1:0] word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [1:0]             byte_count,
  output logic                   overflow,
  output logic                   frame_err,
  output logic                   timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
    $error("uart_word_rx_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  asmState_e              state;
  logic [UART_WORD_W-1:0] shiftReg;
  logic [UART_WORD_W-1:0] nextShift;
  logic                   byteAccept;
  logic                   wordDone;
  logic                   idleExpired;

  // A framing error on the same cycle as a byte discards that byte.
  assign byteAccept = byte_valid && !byte_error;
  assign nextShift  = {byte_data, shiftReg[UART_WORD_W-1:8]};
  assign wordDone   = byteAccept && (state == S_COLLECT)
                      && (byte_count == 2'(UART_BYTES_PER_WORD - 1));

`ifdef UART_RX_TIMEOUT_EN
  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idleTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state == S_COLLECT),
    .restart(byteAccept),
    .expired(idleExpired)
  );
`else
  assign idleExpired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shiftReg   <= '0;
      byte_count <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;

      // Assembly: error beats byte, byte beats silence expiry.
      if (byte_error) begin
        state      <= S_IDLE;
        shiftReg   <= '0;
        byte_count <= '0;
        frame_err  <= 1'b1;
      end else if (byte_valid) begin
        if (wordDone) begin
          state      <= S_IDLE;
          shiftReg   <= '0;
          byte_count <= '0;
        end else begin
          state      <= S_COLLECT;
          shiftReg   <= nextShift;
          byte_count <= byte_count + 1'b1;
        end
      end else if (idleExpired) begin
        state      <= S_IDLE;
        shiftReg   <= '0;
        byte_count <= '0;
        timeout    <= 1'b1;
      end

      // Holding register: a completed word replaces the held one only if it is being consumed.
      if (wordDone) begin
        if (!word_valid || word_ready) begin
          word_data  <= nextShift;
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx_ctrl.sv
// Directed bench for uart_word_rx_ctrl; timeout checks adapt to UART_RX_TIMEOUT_EN.
module tb_uart_word_rx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_error;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  byte_count;
  logic        overflow;
  logic        frame_err;
  logic        timeout;

  int checks = 0;
  int fails  = 0;

  uart_word_rx_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_error(byte_error),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .byte_count(byte_count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_error = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data",  word_data,       32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_pulses",     {29'd0, overflow, frame_err, timeout}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic word with consumer always ready
    word_ready = 1'b1;
    sendByte(8'h11); chk("t1_count1", 32'(byte_count), 32'd1);
    chk("t1_nvalid", 32'(word_valid), 32'd0);
    sendByte(8'h22); chk("t1_count2", 32'(byte_count), 32'd2);
    sendByte(8'h33); chk("t1_count3", 32'(byte_count), 32'd3);
    chk("t1_nvalid3", 32'(word_valid), 32'd0);
    sendByte(8'h44); chk("t1_count0", 32'(byte_count), 32'd0);
    chk("t1_valid", 32'(word_valid), 32'd1);
    chk("t1_data",  word_data, 32'h44332211);
    tick();
    chk("t1_consumed", 32'(word_valid), 32'd0);

    // Overflow: eight bytes with the consumer stalled
    word_ready = 1'b0;
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    chk("t2_valid", 32'(word_valid), 32'd1);
    chk("t2_data",  word_data, 32'h04030201);
    chk("t2_no_ovf", 32'(overflow), 32'd0);
    sendByte(8'h05); sendByte(8'h06); sendByte(8'h07);
    chk("t2_count3", 32'(byte_count), 32'd3);
    chk("t2_no_ovf7", 32'(overflow), 32'd0);
    sendByte(8'h08);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_held", word_data, 32'h04030201);
    chk("t2_count0", 32'(byte_count), 32'd0);
    tick();
    chk("t2_ovf_once", 32'(overflow), 32'd0);
    chk("t2_still_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    tick();
    chk("t2_drained", 32'(word_valid), 32'd0);

    // Framing error discards a partial word
    sendByte(8'hAA); sendByte(8'hBB);
    byte_error = 1'b1;
    tick();
    byte_error = 1'b0;
    chk("t3_ferr", 32'(frame_err), 32'd1);
    chk("t3_count0", 32'(byte_count), 32'd0);
    sendByte(8'h01);
    chk("t3_ferr_once", 32'(frame_err), 32'd0);
    chk("t3_count1", 32'(byte_count), 32'd1);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    chk("t3_valid", 32'(word_valid), 32'd1);
    chk("t3_data",  word_data, 32'h04030201);
    tick();
    chk("t3_consumed", 32'(word_valid), 32'd0);

    // Error and byte on the same cycle: error wins
    sendByte(8'hAA);
    byte_valid = 1'b1; byte_data = 8'hBB; byte_error = 1'b1;
    tick();
    byte_valid = 1'b0; byte_error = 1'b0;
    chk("t3b_ferr", 32'(frame_err), 32'd1);
    chk("t3b_count0", 32'(byte_count), 32'd0);
    sendByte(8'hCC);
    chk("t3b_count1", 32'(byte_count), 32'd1);
    byte_error = 1'b1;
    tick();
    byte_error = 1'b0;
    chk("t3b_clear", 32'(byte_count), 32'd0);

    // Completion on the same cycle the held word is accepted
    word_ready = 1'b0;
    sendByte(8'h10); sendByte(8'h20); sendByte(8'h30); sendByte(8'h40);
    chk("t5_first", word_data, 32'h40302010);
    sendByte(8'h50); sendByte(8'h60); sendByte(8'h70);
    word_ready = 1'b1;
    sendByte(8'h80);
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    chk("t5_valid", 32'(word_valid), 32'd1);
    chk("t5_data", word_data, 32'h80706050);
    tick();
    chk("t5_consumed", 32'(word_valid), 32'd0);

`ifdef UART_RX_TIMEOUT_EN
    // Silence timeout: pulse 16 cycles after the lone byte
    sendByte(8'h55);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_quiet", {30'd0, timeout, frame_err}, 32'd0);
    end
    chk("t4_count_held", 32'(byte_count), 32'd1);
    tick();
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_count0", 32'(byte_count), 32'd0);
    tick();
    chk("t4_timeout_once", 32'(timeout), 32'd0);

    // A byte on the expiry cycle wins
    sendByte(8'h55);
    for (int i = 0; i < 15; i++) tick();
    sendByte(8'h66);
    chk("t4b_no_timeout", 32'(timeout), 32'd0);
    chk("t4b_count2", 32'(byte_count), 32'd2);
    tick();
    chk("t4b_still_none", 32'(timeout), 32'd0);
    chk("t4b_count_kept", 32'(byte_count), 32'd2);
`else
    // No timer: a partial word waits indefinitely
    sendByte(8'h55);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t4_no_timeout", 32'(timeout), 32'd0);
    end
    chk("t4_count_held", 32'(byte_count), 32'd1);
`endif
    byte_error = 1'b1;
    tick();
    byte_error = 1'b0;
    chk("t4_clear", 32'(byte_count), 32'd0);

    // Asynchronous reset mid-word with a held word
    word_ready = 1'b0;
    sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3); sendByte(8'hA4);
    sendByte(8'hB1); sendByte(8'hB2); sendByte(8'hB3);
    chk("t6_pre_valid", 32'(word_valid), 32'd1);
    chk("t6_pre_count", 32'(byte_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(word_valid), 32'd0);
    chk("t6_rst_count", 32'(byte_count), 32'd0);
    chk("t6_rst_data",  word_data, 32'd0);
    chk("t6_rst_pulses", {29'd0, overflow, frame_err, timeout}, 32'd0);
    tick();
    rst_n = 1'b1;
    word_ready = 1'b1;
    tick();
    sendByte(8'hC1);
    chk("t6_count1", 32'(byte_count), 32'd1);
    sendByte(8'hC2); sendByte(8'hC3); sendByte(8'hC4);
    chk("t6_valid", 32'(word_valid), 32'd1);
    chk("t6_data",  word_data, 32'hC4C3C2C1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_word_rx_ctrl.md
# uart_word_rx_ctrl

Receive-side controller between the UART byte receiver and the word-level consumers. It sequences incoming bytes into 32-bit little-endian words and discards partial words on byte framing errors or inter-byte silence. It presents each completed word through a valid/ready handshake with a one-word output holding register. It replaces edge-triggered word assembly with a fully synchronous, resettable datapath in the `clk` domain.

## Interface
- `TIMEOUT_CYCLES`, default 100000 — clock cycles of silence after a byte before a partial word is discarded; must be ≥ 2.
- `clk` input 1 — system clock; all logic on the rising edge.
- `rst_n` input 1 — one clock; reset is asynchronous and active-low.
- `byte_valid` input 1 — single-cycle pulse: `byte_data` is a received byte.
- `byte_data` input 8 — received byte; sampled only when `byte_valid`=1.
- `byte_error` input 1 — single-cycle pulse: the byte receiver saw a stop-bit/framing error.
- `word_data` output 32 — assembled word; first received byte in [7:0], fourth in [31:24].
- `word_valid` output 1 — `word_data` holds an unconsumed word.
- `word_ready` input 1 — consumer accepts the word this cycle.
- `byte_count` output 2 — bytes collected in the current partial word (0–3).
- `overflow` output 1 — one-cycle pulse: a completed word was dropped because the holding register was full.
- `frame_err` output 1 — one-cycle pulse: the partial word was discarded due to `byte_error`.
- `timeout` output 1 — one-cycle pulse: the partial word was discarded due to inter-byte silence.

## Operation
- Assembly FSM states:
  - `S_IDLE`: `byte_count`=0.
  - `S_COLLECT`: 1–3 bytes held in the shift register.
- Transitions:
  - On `byte_valid`, the byte shifts in at [31:24] and prior content shifts right 8.
  - `S_IDLE` → `S_COLLECT` on the first byte.
  - On the 4th byte: the word completes, `byte_count`→0, and the FSM returns to `S_IDLE`.
- `byte_error` in any state:
  - Clear the shift register and `byte_count`, go to `S_IDLE`, and pulse `frame_err`.
  - A `byte_valid` in the same cycle is discarded; error wins.
- Holding register on word completion:
  - If `word_valid`=0: load `word_data`, set `word_valid`.
  - If `word_valid`=1 and `word_ready`=1: load the new word; `word_valid` stays 1.
  - If `word_valid`=1 and `word_ready`=0: the held word is kept, the new word is dropped, and `overflow` pulses.
- Consumption: `word_valid`&&`word_ready` with no completion → `word_valid` clears next cycle. `word_data` keeps its last value; it is don't-care when invalid.
- `word_ready` while `word_valid`=0 is ignored.
- Reset values: all outputs 0; FSM `S_IDLE`; shift register and timeout counter 0. Reset mid-word discards everything, including a held word.

## Timing
- Completion latency: the 4th `byte_valid` at edge N → `word_valid`=1 and `word_data` valid after edge N (visible in cycle N+1).
- `frame_err`, `overflow` and `timeout` are registered, high for exactly one cycle, and follow the causing edge.
- Timeout counter:
  - Runs only in `S_COLLECT` and reloads to 0 on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES-1`: discard the partial word, go to `S_IDLE`, pulse `timeout`.
  - `byte_valid` in the same cycle as expiry wins: the byte is accepted and the counter is reset.
- Back-to-back `byte_valid` on consecutive cycles is supported: full throughput of one byte per cycle.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - The timeout counter and `timeout` output behave as above.
- `UART_RX_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A partial word waits indefinitely; only `byte_error` or reset clears it.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `uart_pkg` holds:
  - the assembly state enum (`S_IDLE`, `S_COLLECT`);
  - `UART_BYTES_PER_WORD`=4 and `UART_WORD_W`=32;
  - the counter width derivation function (clog2 of `TIMEOUT_CYCLES`).
- One sub-module, `uart_idle_timer`:
  - Parameterized by `TIMEOUT_CYCLES`.
  - Inputs: `clk`, `rst_n`, `run`, `restart`. Output: `expired` pulse.
  - Instantiated only under `UART_RX_TIMEOUT_EN`.

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44, with `word_ready`=1 → `word_data`=0x44332211 and `word_valid` high for exactly 1 cycle, starting the cycle after the 4th byte; `byte_count` sequence 1,2,3,0.
- Eight bytes 0x01–0x08 back-to-back, `word_ready`=0 until after the 8th byte → `word_data`=0x04030201 held; `overflow` pulses once on the 8th byte; then `word_ready`=1 → `word_valid` clears.
- Bytes 0xAA, 0xBB, then `byte_error`, then 0x01, 0x02, 0x03, 0x04 → `frame_err` pulses once; `word_data`=0x04030201 (no 0xAA/0xBB remnants).
- `TIMEOUT_CYCLES`=16, macro defined; one byte 0x55, then silence → `timeout` pulses exactly 16 cycles after the byte and `byte_count`=0. Same run with a byte landing on the expiry cycle → no `timeout` pulse and `byte_count`=2.
- Word completes on the same cycle `word_ready` accepts the previous word → no overflow, `word_valid` stays 1, new data loaded.
- Assert `rst_n`=0 after 3 bytes and a held word → all outputs 0 immediately; the next 4 bytes produce a correct word.
